// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular FIFO; queued words go out back-to-back.
// Frame: start, DATA_BITS data LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_fifo #(
    parameter int CLOCK_SPEED = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_WIDTH = CLOCK_SPEED / BAUD_RATE;
    localparam int BCW        = (BAUD_WIDTH > 1) ? $clog2(BAUD_WIDTH) : 1;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int CW         = AW + 1;
    localparam int IW         = 4;

    localparam logic [BCW-1:0] BAUD_LAST  = BCW'(BAUD_WIDTH - 1);
    localparam logic [IW-1:0]  DATA_LAST  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0]  STOP_LAST  = IW'(STOP_BITS - 1);
    localparam logic [CW-1:0]  FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic           PARITY_ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;
    logic [BCW-1:0]         baud_cnt_r;
    logic [BCW-1:0]         baud_cnt_next_s;
    logic [IW-1:0]          bit_idx_r;
    logic [IW-1:0]          bit_idx_next_s;
    logic [DATA_BITS-1:0]   shift_r;
    logic [DATA_BITS-1:0]   shift_next_s;
    logic                   parity_r;
    logic                   parity_next_s;
    logic                   tx_r;
    logic                   tx_next_s;
    logic                   tx_done_r;
    logic [DATA_BITS-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic                   push_s;
    logic                   pop_s;
    logic                   bit_end_s;
    logic                   stop_end_s;
    logic                   fifo_nempty_s;
    logic [DATA_BITS-1:0]   head_s;

    assign wr_ready   = (count_r != FULL_COUNT);
    assign push_s     = wr_valid && wr_ready;
    assign tx         = tx_r;
    assign tx_done    = tx_done_r;
    assign busy       = (state_r != ST_IDLE);
    assign fifo_count = count_r;

    // Bit-boundary and FIFO status decode shared by the FSM and datapath
    always_comb begin
        bit_end_s     = (baud_cnt_r == BAUD_LAST);
        stop_end_s    = (state_r == ST_STOP) && bit_end_s && (bit_idx_r == STOP_LAST);
        fifo_nempty_s = (count_r != {CW{1'b0}});
        head_s        = mem_r[rd_ptr_r];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fifo_nempty_s) state_next_s = ST_START;
                else               state_next_s = ST_IDLE;
            end
            ST_START: begin
                if (bit_end_s) state_next_s = ST_DATA;
                else           state_next_s = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_r == DATA_LAST)) begin
                    state_next_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) state_next_s = ST_STOP;
                else           state_next_s = ST_PARITY;
            end
            ST_STOP: begin
                if (stop_end_s) state_next_s = fifo_nempty_s ? ST_START : ST_IDLE;
                else            state_next_s = ST_STOP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: next values for counters, shifter and the registered line
    always_comb begin
        pop_s           = (state_next_s == ST_START) &&
                          ((state_r == ST_IDLE) || (state_r == ST_STOP));
        baud_cnt_next_s = baud_cnt_r;
        bit_idx_next_s  = bit_idx_r;
        shift_next_s    = shift_r;
        parity_next_s   = parity_r;
        tx_next_s       = 1'b1;

        if ((state_r == ST_IDLE) || bit_end_s) baud_cnt_next_s = {BCW{1'b0}};
        else                                   baud_cnt_next_s = baud_cnt_r + BCW'(1'b1);

        // Index counts data bits in DATA and stop bits in STOP; it restarts on any state change
        if (state_next_s != state_r) begin
            bit_idx_next_s = {IW{1'b0}};
        end else if (bit_end_s && ((state_r == ST_DATA) || (state_r == ST_STOP))) begin
            bit_idx_next_s = bit_idx_r + IW'(1'b1);
        end else begin
            bit_idx_next_s = bit_idx_r;
        end

        if (pop_s) begin
            shift_next_s  = head_s;
            parity_next_s = calc_parity(head_s, PARITY_ODD);
        end else if ((state_r == ST_DATA) && bit_end_s && (state_next_s == ST_DATA)) begin
            shift_next_s  = shift_r >> 1;
            parity_next_s = parity_r;
        end else begin
            shift_next_s  = shift_r;
            parity_next_s = parity_r;
        end

        case (state_next_s)
            ST_IDLE:   tx_next_s = 1'b1;
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_next_s[0];
            ST_PARITY: tx_next_s = parity_r;
            ST_STOP:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // Transmit datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt_r <= {BCW{1'b0}};
            bit_idx_r  <= {IW{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            tx_done_r  <= 1'b0;
        end else begin
            baud_cnt_r <= baud_cnt_next_s;
            bit_idx_r  <= bit_idx_next_s;
            shift_r    <= shift_next_s;
            parity_r   <= parity_next_s;
            tx_r       <= tx_next_s;
            tx_done_r  <= stop_end_s;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {DATA_BITS{1'b0}};
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, even/odd parity, 7N2, FIFO fill/drain,
// simultaneous push/pop and mid-frame reset. BAUD_WIDTH is 10 in every instance.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wv;
    logic [7:0] wd0, wd1, wd2;
    logic [6:0] wd3;
    logic [3:0] ready_v, tx_v, busy_v, done_v;
    logic [2:0] fc0, fc1, fc2, fc3;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLOCK_SPEED(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .wr_valid(wv[0]), .wr_data(wd0), .wr_ready(ready_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]), .fifo_count(fc0));
    uart_tx_fifo #(.CLOCK_SPEED(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .wr_valid(wv[1]), .wr_data(wd1), .wr_ready(ready_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]), .fifo_count(fc1));
    uart_tx_fifo #(.CLOCK_SPEED(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .wr_valid(wv[2]), .wr_data(wd2), .wr_ready(ready_v[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]), .fifo_count(fc2));
    uart_tx_fifo #(.CLOCK_SPEED(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .clk(clk), .rst(rst), .wr_valid(wv[3]), .wr_data(wd3), .wr_ready(ready_v[3]),
        .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]), .fifo_count(fc3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the start bit of instance d
    task automatic wait_fall(input int d, input string tag);
        int n = 0;
        while (tx_v[d] !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, " start"}, 32'(tx_v[d]), 32'd0);
    endtask

    // Called at the first negedge of a frame (j=0); checks bit centres and the tx_done pulse,
    // returns at j = 10*nb where tx_done must be high.
    task automatic run_frame(input int d, input string tag, input logic [15:0] bits, input int nb);
        repeat (5) @(negedge clk);
        for (int k = 0; k < nb; k++) begin
            check($sformatf("%s bit%0d", tag, k), 32'(tx_v[d]), 32'(bits[k]));
            if (k < nb - 1) repeat (10) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check({tag, " done early"}, 32'(done_v[d]), 32'd0);
        @(negedge clk);
        check({tag, " done"}, 32'(done_v[d]), 32'd1);
    endtask

    initial begin
        logic [7:0] fw [6];
        int         ec [6];
        int         er [6];
        int         ec_end [4];
        int         bad;

        fw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        ec = '{1, 1, 2, 3, 4, 4};
        er = '{1, 1, 1, 1, 0, 0};
        ec_end = '{2, 1, 0, 0};

        rst = 1'b0;
        wv  = 4'b0000;
        wd0 = 8'h00; wd1 = 8'h00; wd2 = 8'h00; wd3 = 7'h00;
        repeat (3) @(negedge clk);
        check("rst tx", 32'(tx_v[0]), 32'd1);
        check("rst busy", 32'(busy_v[0]), 32'd0);
        check("rst done", 32'(done_v[0]), 32'd0);
        check("rst ready", 32'(ready_v[0]), 32'd1);
        check("rst count", 32'(fc0), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle tx", 32'(tx_v[0]), 32'd1);

        // 8N1 single frame, 0xA5
        wv[0] = 1'b1; wd0 = 8'hA5;
        @(negedge clk);
        wv[0] = 1'b0;
        check("8n1 count1", 32'(fc0), 32'd1);
        check("8n1 tx pre", 32'(tx_v[0]), 32'd1);
        check("8n1 busy pre", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        check("8n1 tx fall", 32'(tx_v[0]), 32'd0);
        check("8n1 busy", 32'(busy_v[0]), 32'd1);
        check("8n1 count0", 32'(fc0), 32'd0);
        run_frame(0, "8n1", 16'({1'b1, 8'hA5, 1'b0}), 10);
        check("8n1 busy end", 32'(busy_v[0]), 32'd0);
        check("8n1 tx end", 32'(tx_v[0]), 32'd1);
        @(negedge clk);
        check("8n1 done once", 32'(done_v[0]), 32'd0);

        // Even parity, 0x07: parity bit 1, frame 110 cycles
        wv[1] = 1'b1; wd1 = 8'h07;
        @(negedge clk);
        wv[1] = 1'b0;
        wait_fall(1, "8e1");
        run_frame(1, "8e1", 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
        check("8e1 busy end", 32'(busy_v[1]), 32'd0);

        // Odd parity, 0x07: parity bit 0
        wv[2] = 1'b1; wd2 = 8'h07;
        @(negedge clk);
        wv[2] = 1'b0;
        wait_fall(2, "8o1");
        run_frame(2, "8o1", 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
        check("8o1 busy end", 32'(busy_v[2]), 32'd0);

        // 7 data bits, 2 stop bits, 0x55: frame 100 cycles
        wv[3] = 1'b1; wd3 = 7'h55;
        @(negedge clk);
        wv[3] = 1'b0;
        wait_fall(3, "7n2");
        run_frame(3, "7n2", 16'({2'b11, 7'h55, 1'b0}), 10);
        check("7n2 busy end", 32'(busy_v[3]), 32'd0);

        // FIFO full and drain: six consecutive writes, the sixth is dropped
        for (int i = 0; i < 6; i++) begin
            wv[0] = 1'b1; wd0 = fw[i];
            @(negedge clk);
            check($sformatf("full count w%0d", i), 32'(fc0), 32'(ec[i]));
            check($sformatf("full ready w%0d", i), 32'(ready_v[0]), 32'(er[i]));
        end
        wv[0] = 1'b0;
        repeat (95) @(negedge clk);
        check("full f0 done early", 32'(done_v[0]), 32'd0);
        @(negedge clk);
        check("full f0 done", 32'(done_v[0]), 32'd1);
        check("full f0 gap", 32'(tx_v[0]), 32'd0);
        check("full f0 count", 32'(fc0), 32'd3);
        for (int i = 1; i < 5; i++) begin
            run_frame(0, $sformatf("full f%0d", i), 16'({1'b1, fw[i], 1'b0}), 10);
            check($sformatf("full f%0d count", i), 32'(fc0), 32'(ec_end[i-1]));
            if (i < 4) begin
                check($sformatf("full f%0d gap", i), 32'(tx_v[0]), 32'd0);
            end else begin
                check("full busy end", 32'(busy_v[0]), 32'd0);
                check("full tx end", 32'(tx_v[0]), 32'd1);
            end
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
        end
        check("full no 6th frame", 32'(bad), 32'd0);

        // Simultaneous push/pop at end of stop with two words queued
        wv[0] = 1'b1; wd0 = 8'hC3;
        @(negedge clk);
        wd0 = 8'h55;
        @(negedge clk);
        wd0 = 8'h5A;
        @(negedge clk);
        wv[0] = 1'b0;
        check("pp count before", 32'(fc0), 32'd2);
        repeat (98) @(negedge clk);
        wv[0] = 1'b1; wd0 = 8'h99;
        @(negedge clk);
        wv[0] = 1'b0;
        check("pp count", 32'(fc0), 32'd2);
        check("pp done", 32'(done_v[0]), 32'd1);
        check("pp next start", 32'(tx_v[0]), 32'd0);

        // Reset during data bit 3 of 0x55 (bit value 0) with 5A and 99 queued
        repeat (45) @(negedge clk);
        check("rst mid bit3", 32'(tx_v[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("rst mid tx", 32'(tx_v[0]), 32'd1);
        check("rst mid count", 32'(fc0), 32'd0);
        check("rst mid busy", 32'(busy_v[0]), 32'd0);
        check("rst mid done", 32'(done_v[0]), 32'd0);
        check("rst mid ready", 32'(ready_v[0]), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || fc0 !== 3'd0) bad++;
        end
        check("rst stays idle", 32'(bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO. It supports configurable data width, parity and stop-bit count, and accepts bytes through a valid/ready write port. It serialises queued words back-to-back onto `tx` with no idle gap between frames. It is the drop-in successor to the fixed 8N1 single-word transmitter, and sits between the host-side data producer and the external serial pin.

## Interface
- `CLOCK_SPEED`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate. `BAUD_WIDTH = CLOCK_SPEED / BAUD_RATE` is integer-truncated and must be ≥ 2.
- `DATA_BITS`, 8: payload bits per frame, legal range 5..9.
- `PARITY`, 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries. Must be a power of 2 and ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_valid`  in  1  write request.
- `wr_data`  in  DATA_BITS  word to transmit.
- `wr_ready`  out  1  FIFO not full.
- `tx`  out  1  serial line, registered output.
- `busy`  out  1  a frame is in progress (state != IDLE).
- `tx_done`  out  1  one-cycle pulse at the end of each frame.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

## Operation
- **Frame format:** start bit (0), then DATA_BITS data bits LSB first, then an optional parity bit, then STOP_BITS stop bits (1).
- **Data polarity:** data is transmitted true, not inverted.
- **Parity bit:** even mode sends the XOR of the data bits; odd mode sends its complement.
- **Write port:** a write is accepted on any edge where `wr_valid && wr_ready`.
  - `wr_ready = (fifo_count != FIFO_DEPTH)`.
  - A write while full is ignored; no FIFO state changes.
- **FIFO:** circular buffer with wrapping read and write pointers.
  - A push and a pop on the same edge leave `fifo_count` unchanged.
  - A pop from an empty FIFO never occurs.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. Transitions:
  - IDLE → START when the FIFO is non-empty. The head word is popped into the shift register on that edge.
  - START → DATA after BAUD_WIDTH cycles.
  - DATA → DATA after each bit; the shift register shifts right and the bit index increments.
  - DATA → PARITY after bit DATA_BITS-1 when PARITY != 0; otherwise DATA → STOP.
  - PARITY → STOP after BAUD_WIDTH cycles.
  - STOP lasts STOP_BITS × BAUD_WIDTH cycles. At its end the FSM goes to START if the FIFO is non-empty (popping the next word on the same edge), otherwise to IDLE.
- **Baud counter:** runs 0..BAUD_WIDTH-1, width $clog2(BAUD_WIDTH). It resets to 0 on every bit boundary and is held at 0 in IDLE.
- **`tx_done`:** asserted for exactly one cycle, on the cycle following the final stop-bit edge. This applies both for back-to-back frames and when returning to IDLE.
- **Reset (including mid-frame):**
  - `tx=1`, `busy=0`, `tx_done=0`, `wr_ready=1`, `fifo_count=0`, state IDLE.
  - Pointers, counters and the shift register are cleared.
  - An in-flight frame is aborted with no `tx_done`, and FIFO contents are discarded.

## Timing
- **Write latency:** a write accepted at edge N raises `fifo_count` after edge N.
- **Start of frame:** if the FSM is IDLE, it pops at edge N+1, and `tx` falls to 0 after edge N+1 (one cycle of latency, registered).
- **Frame length:** exactly `BAUD_WIDTH × (1 + DATA_BITS + (PARITY!=0) + STOP_BITS)` cycles of `tx` per frame.
- **Back-to-back frames:** zero idle cycles between consecutive frames when the FIFO is non-empty.
- **`busy`:** high from the edge that enters START through the edge that enters IDLE.
- **`wr_ready`:** depends only on registered `fifo_count`; there is no combinational path from `wr_valid`.

## Test plan
- **8N1 single frame** (CLOCK_SPEED=1000, BAUD_RATE=100, BAUD_WIDTH=10): write 0xA5 into an empty FIFO.
  - Required: `tx` = 0 for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles.
  - Required: `tx_done` pulses once, 100 cycles after `tx` falls.
- **Parity:** DATA_BITS=8, write 0x07.
  - PARITY=1: parity bit is 1.
  - PARITY=2: parity bit is 0.
  - Required frame length: 110 cycles in both cases.
- **7 data bits, 2 stop bits** (DATA_BITS=7, STOP_BITS=2): write 0x55.
  - Required: data 1,0,1,0,1,0,1, then `tx` high for 20 cycles; frame length 100 cycles.
- **FIFO full and drain** (FIFO_DEPTH=4): issue 6 consecutive writes.
  - Required: the first word pops immediately; `fifo_count` reaches 4 and `wr_ready` falls after the 5th write; the 6th write is ignored.
  - Required: exactly 5 frames with no idle gap between them, and 5 `tx_done` pulses.
- **Simultaneous push/pop:** with `fifo_count`=2, write on the same edge as the end-of-stop pop.
  - Required: `fifo_count` stays 2.
- **Reset mid-frame:** assert `rst` low during data bit 3 with 2 words queued.
  - Required: `tx`=1 and `fifo_count`=0 immediately, with no `tx_done`.
  - Required: after release, the block stays IDLE and `tx` stays 1.
